// File: rtl/segm14_capture.sv
// segm14_capture: recovers ASCII text from a multiplexed 12-digit 14-segment display scan.
//
// Pipeline: S1 registers sel/segm; S2 decodes the pattern, checks the select and the scan
// order, and writes into a double-banked 12x8 frame buffer. Completed frames are handed to
// the read side by swapping banks. The read side streams chars 0..11 on a valid/ready port.
//
// Optional feature: define SEGM14_ERRCNT_EN to add err_count[7:0], a saturating count of
// err_sel, err_seq and overrun pulses.

module segm14_capture (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sel,
    input  logic [13:0] segm,
    output logic [7:0]  out_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        err_sel,
    output logic        err_seq,
    output logic        overrun
`ifdef SEGM14_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [3:0] LastPos = 4'd11;

    typedef enum logic [0:0] {
        StSync    = 1'b0,
        StCapture = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Segment pattern to ASCII; anything unrecognised becomes '?'.
    // ------------------------------------------------------------------
    function automatic logic [7:0] decode_seg(input logic [13:0] s);
        logic [7:0] c;
        case (s)
            14'h3BC0: c = 8'h41; // A
            14'h3C52: c = 8'h42; // B
            14'h2780: c = 8'h45; // E
            14'h0700: c = 8'h4C; // L
            14'h1B24: c = 8'h4E; // N
            14'h3F00: c = 8'h4F; // O
            14'h33C0: c = 8'h50; // P
            14'h36C0: c = 8'h32; // 2
            14'h3C40: c = 8'h33; // 3
            14'h3F09: c = 8'h30; // 0
            14'h0000: c = 8'h20; // space
            default:  c = 8'h3F; // ?
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [11:0] sel_q;
    logic [13:0] segm_q;
    // Marks S1 as holding a real sample; the cleared post-reset S1 must not be flagged.
    logic        s1_vld_q;

    state_e      st_q, st_d;
    logic [3:0]  exp_q, exp_d;

    logic [3:0]  pos;
    logic        onehot;
    logic [7:0]  chr;

    logic        wr_en;
    logic        sel_bad;
    logic        seq_bad;
    logic        frame_done;

    logic [7:0]  mem_q [2][12];
    logic        wr_bank_q, wr_bank_d;
    logic        rd_full_q, rd_full_d;
    logic [3:0]  rd_idx_q, rd_idx_d;
    logic        xfer;
    logic        rd_free;
    logic        swap;

    logic        err_sel_q, err_sel_d;
    logic        err_seq_q, err_seq_d;
    logic        overrun_q, overrun_d;

    // ------------------------------------------------------------------
    // S1: register the raw scan inputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= 12'd0;
            segm_q   <= 14'd0;
            s1_vld_q <= 1'b0;
        end else begin
            sel_q    <= sel;
            segm_q   <= segm;
            s1_vld_q <= 1'b1;
        end
    end

    // Position index and one-hot check of the registered select.
    always_comb begin
        pos = 4'd0;
        for (int k = 0; k < 12; k++) begin
            if (sel_q[k]) pos = 4'(k);
        end
        onehot = (sel_q != 12'd0) && ((sel_q & (sel_q - 12'd1)) == 12'd0);
        chr    = decode_seg(segm_q);
    end

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= StSync;
            exp_q <= 4'd0;
        end else begin
            st_q  <= st_d;
            exp_q <= exp_d;
        end
    end

    // Next state: follow the expected position, resync on any disturbance.
    always_comb begin
        st_d  = st_q;
        exp_d = exp_q;
        if (s1_vld_q) begin
            if (!onehot) begin
                st_d  = StSync;
                exp_d = 4'd0;
            end else begin
                case (st_q)
                    StSync: begin
                        if (pos == 4'd0) begin
                            st_d  = StCapture;
                            exp_d = 4'd1;
                        end
                    end
                    StCapture: begin
                        if (pos == exp_q) begin
                            if (pos == LastPos) begin
                                st_d  = StSync;
                                exp_d = 4'd0;
                            end else begin
                                exp_d = exp_q + 4'd1;
                            end
                        end else if (pos == 4'd0) begin
                            // Out-of-order position 0 restarts the frame in place.
                            exp_d = 4'd1;
                        end else begin
                            st_d  = StSync;
                            exp_d = 4'd0;
                        end
                    end
                    default: begin
                        st_d  = StSync;
                        exp_d = 4'd0;
                    end
                endcase
            end
        end
    end

    // FSM outputs: buffer write strobe, error conditions and frame completion.
    always_comb begin
        wr_en      = 1'b0;
        sel_bad    = 1'b0;
        seq_bad    = 1'b0;
        frame_done = 1'b0;
        if (s1_vld_q) begin
            if (!onehot) begin
                sel_bad = 1'b1;
            end else begin
                case (st_q)
                    StSync: begin
                        wr_en = (pos == 4'd0);
                    end
                    StCapture: begin
                        if (pos == exp_q) begin
                            wr_en      = 1'b1;
                            frame_done = (pos == LastPos);
                        end else begin
                            seq_bad = 1'b1;
                            wr_en   = (pos == 4'd0);
                        end
                    end
                    default: begin
                        wr_en = 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer: two banks, wr_bank_q selects the one being filled.
    // ------------------------------------------------------------------
    // Character storage; contents are only observable through the gated read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank_q][pos] <= chr;
        end
    end

    // Bank handoff and read-side sequencing.
    always_comb begin
        xfer = rd_full_q && out_ready;
        // The read bank may be refilled if empty or if its last char leaves on this edge.
        rd_free = !rd_full_q || (xfer && (rd_idx_q == LastPos));
        swap    = frame_done && rd_free;

        wr_bank_d = wr_bank_q;
        rd_full_d = rd_full_q;
        rd_idx_d  = rd_idx_q;

        if (xfer) begin
            if (rd_idx_q == LastPos) begin
                rd_full_d = 1'b0;
                rd_idx_d  = 4'd0;
            end else begin
                rd_idx_d = rd_idx_q + 4'd1;
            end
        end

        if (swap) begin
            wr_bank_d = ~wr_bank_q;
            rd_full_d = 1'b1;
            rd_idx_d  = 4'd0;
        end

        // err_sel has priority; the others cannot coincide with it or each other anyway.
        err_sel_d = sel_bad;
        err_seq_d = seq_bad && !sel_bad;
        overrun_d = frame_done && !rd_free && !sel_bad;
    end

    // Read-side and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_full_q <= 1'b0;
            rd_idx_q  <= 4'd0;
            err_sel_q <= 1'b0;
            err_seq_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_full_q <= rd_full_d;
            rd_idx_q  <= rd_idx_d;
            err_sel_q <= err_sel_d;
            err_seq_q <= err_seq_d;
            overrun_q <= overrun_d;
        end
    end

    // Output port drive; out_char reads 0x00 whenever nothing is presented.
    always_comb begin
        out_valid = rd_full_q;
        out_last  = rd_full_q && (rd_idx_q == LastPos);
        out_char  = rd_full_q ? mem_q[~wr_bank_q][rd_idx_q] : 8'h00;
        err_sel   = err_sel_q;
        err_seq   = err_seq_q;
        overrun   = overrun_q;
    end

`ifdef SEGM14_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating count of error pulses, advanced on the edge that raises the pulse.
    always_comb begin
        err_count_d = err_count_q;
        if ((err_sel_d || err_seq_d || overrun_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_segm14_capture.sv
// Directed bench for segm14_capture: scans frames, observes the stream and error pulses.
module tb_segm14_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] sel;
    logic [13:0] segm;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        err_sel;
    logic        err_seq;
    logic        overrun;
`ifdef SEGM14_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    always #5 clk = ~clk;

    segm14_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .segm      (segm),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .err_sel   (err_sel),
        .err_seq   (err_seq),
        .overrun   (overrun)
`ifdef SEGM14_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [13:0] frm_seg [3][12];
    logic [7:0]  frm_chr [3][12];

    logic [7:0] rx_chr [$];
    logic       rx_last [$];
    int         n_err_sel;
    int         n_err_seq;
    int         n_ovr;
    int         n_unstable;

    // Observer: records transfers and pulses, and watches stability under backpressure.
    initial begin : monitor
        logic       stall;
        logic [7:0] stall_chr;
        logic       stall_last;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall && !(out_valid === 1'b1 && out_char === stall_chr &&
                               out_last === stall_last))
                    n_unstable++;
                if (out_valid && out_ready) begin
                    rx_chr.push_back(out_char);
                    rx_last.push_back(out_last);
                end
                if (err_sel) n_err_sel++;
                if (err_seq) n_err_seq++;
                if (overrun) n_ovr++;
                stall      = out_valid && !out_ready;
                stall_chr  = out_char;
                stall_last = out_last;
            end
        end
    end

    task automatic clear_obs();
        rx_chr.delete();
        rx_last.delete();
        n_err_sel  = 0;
        n_err_seq  = 0;
        n_ovr      = 0;
        n_unstable = 0;
    endtask

    task automatic send_raw(input logic [11:0] s, input logic [13:0] g);
        @(posedge clk);
        #1;
        sel  = s;
        segm = g;
    endtask

    task automatic send_pos(input int p, input logic [13:0] g);
        logic [11:0] one;
        one = 12'h001;
        send_raw(one << p, g);
    endtask

    task automatic send_frame(input int f);
        for (int p = 0; p < 12; p++) send_pos(p, frm_seg[f][p]);
    endtask

    // Hold a position that SYNC ignores, so idle cycles raise no error.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_raw(12'h002, 14'h0000);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input int f, input int base);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (rx_chr.size() <= base + i) begin
                errors++;
                $display("FAIL %s char %0d: got nothing, expected %h", name, i, frm_chr[f][i]);
            end else if (rx_chr[base+i] !== frm_chr[f][i] || rx_last[base+i] !== (i == 11)) begin
                errors++;
                $display("FAIL %s char %0d: got %h last=%b, expected %h last=%b", name, i,
                         rx_chr[base+i], rx_last[base+i], frm_chr[f][i], (i == 11));
            end
        end
    endtask

    task automatic init_frames();
        frm_seg[0] = '{14'h33C0, 14'h3BC0, 14'h3C52, 14'h2780, 14'h0700, 14'h0700,
                       14'h3F00, 14'h1B24, 14'h36C0, 14'h3F09, 14'h36C0, 14'h3C40};
        frm_chr[0] = '{8'h50, 8'h41, 8'h42, 8'h45, 8'h4C, 8'h4C,
                       8'h4F, 8'h4E, 8'h32, 8'h30, 8'h32, 8'h33};
        frm_seg[1] = '{14'h1B24, 14'h2780, 14'h3F00, 14'h0000, 14'h36C0, 14'h0000,
                       14'h0700, 14'h3BC0, 14'h3C52, 14'h0000, 14'h3F09, 14'h3C40};
        frm_chr[1] = '{8'h4E, 8'h45, 8'h4F, 8'h20, 8'h32, 8'h20,
                       8'h4C, 8'h41, 8'h42, 8'h20, 8'h30, 8'h33};
        frm_seg[2] = frm_seg[0];
        frm_chr[2] = frm_chr[0];
        frm_seg[2][4] = 14'h1234;
        frm_chr[2][4] = 8'h3F;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        sel       = 12'h002;
        segm      = 14'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset out_valid", int'(out_valid), 0);
        check_int("reset out_last", int'(out_last), 0);
        check_int("reset out_char", int'(out_char), 0);
        check_int("reset err pulses", int'({err_sel, err_seq, overrun}), 0);
`ifdef SEGM14_ERRCNT_EN
        check_int("reset err_count", int'(err_count), 0);
`endif
        clear_obs();
        rst_n = 1'b1;
        idle(5);
        check_int("post-reset err_sel", n_err_sel, 0);
        check_int("post-reset out_valid", int'(out_valid), 0);
    endtask

    task automatic test_frame();
        clear_obs();
        send_frame(0);
        idle(20);
        check_int("frame count", rx_chr.size(), 12);
        check_frame("frame", 0, 0);
        check_int("frame err pulses", n_err_sel + n_err_seq + n_ovr, 0);
        check_int("frame drained", int'(out_valid), 0);
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_frame(0);
        send_frame(1);
        idle(20);
        check_int("b2b count", rx_chr.size(), 24);
        check_frame("b2b first", 0, 0);
        check_frame("b2b second", 1, 12);
        check_int("b2b overrun", n_ovr, 0);
    endtask

    task automatic test_backpressure();
        clear_obs();
        out_ready = 1'b0;
        send_frame(0);
        send_frame(1);
        idle(6);
        check_int("stall out_valid", int'(out_valid), 1);
        check_int("stall out_char", int'(out_char), 8'h50);
        check_int("stall out_last", int'(out_last), 0);
        check_int("stall overrun", n_ovr, 1);
        out_ready = 1'b1;
        idle(20);
        check_int("stall stable", n_unstable, 0);
        check_int("stall drain count", rx_chr.size(), 12);
        check_frame("stall drain", 0, 0);
        check_int("stall other errors", n_err_sel + n_err_seq, 0);
    endtask

    task automatic test_bad_sel();
        clear_obs();
        for (int p = 0; p < 5; p++) send_pos(p, frm_seg[1][p]);
        send_raw(12'h003, 14'h3BC0);
        for (int p = 5; p < 12; p++) send_pos(p, frm_seg[1][p]);
        idle(3);
        check_int("badsel err_sel", n_err_sel, 1);
        check_int("badsel err_seq", n_err_seq, 0);
        send_frame(0);
        idle(20);
        check_int("badsel count", rx_chr.size(), 12);
        check_frame("badsel frame", 0, 0);
    endtask

    task automatic test_seq();
        clear_obs();
        send_pos(0, frm_seg[1][0]);
        send_pos(1, frm_seg[1][1]);
        send_pos(2, frm_seg[1][2]);
        send_pos(5, frm_seg[1][5]);
        idle(5);
        check_int("seq skip err_seq", n_err_seq, 1);
        send_pos(0, frm_seg[1][0]);
        send_pos(1, frm_seg[1][1]);
        send_frame(0);
        idle(20);
        check_int("seq restart err_seq", n_err_seq, 2);
        check_int("seq restart count", rx_chr.size(), 12);
        check_frame("seq restart frame", 0, 0);
        check_int("seq other errors", n_err_sel + n_ovr, 0);
    endtask

    task automatic test_unknown_seg();
        clear_obs();
        send_frame(2);
        idle(20);
        check_int("unknown count", rx_chr.size(), 12);
        check_frame("unknown frame", 2, 0);
        check_int("unknown errors", n_err_sel + n_err_seq + n_ovr, 0);
    endtask

    task automatic test_reset_drain();
        clear_obs();
        out_ready = 1'b0;
        send_frame(0);
        idle(4);
        check_int("drain pre-reset valid", int'(out_valid), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("drain reset valid", int'(out_valid), 0);
        check_int("drain reset char", int'(out_char), 0);
`ifdef SEGM14_ERRCNT_EN
        check_int("drain reset err_count", int'(err_count), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(20);
        check_int("drain discarded", rx_chr.size(), 0);
        for (int i = 0; i < 300; i++) send_raw(12'h000, 14'h0000);
        idle(3);
        check_int("zero sel pulses", n_err_sel, 300);
`ifdef SEGM14_ERRCNT_EN
        check_int("err_count saturate", int'(err_count), 255);
`endif
    endtask

    initial begin
        init_frames();
        clear_obs();
        test_reset();
        test_frame();
        test_back_to_back();
        test_backpressure();
        test_bad_sel();
        test_seq();
        test_unknown_seg();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segm14_capture.md
SEGM14_CAPTURE -- requirements
Module: segm14_capture

Interface
REQ-001 The block SHALL have ports: clk input 1, rising-edge system clock.
REQ-002 The block SHALL have ports: rst_n input 1, asynchronous active-low reset.
REQ-003 The block SHALL have ports: sel input 12, one-hot digit select from the 12-digit scan driver; bit k means digit position k.
REQ-004 The block SHALL have ports: segm input 14, segment pattern for the selected digit (bit 13 = segment a … bit 0).
REQ-005 The block SHALL have ports: out_char output 8, decoded ASCII character.
REQ-006 The block SHALL have ports: out_valid output 1, out_char holds a valid character.
REQ-007 The block SHALL have ports: out_ready input 1, consumer accepts out_char.
REQ-008 The block SHALL have ports: out_last output 1, out_char is position 11.
REQ-009 The block SHALL have ports: err_sel output 1, one-cycle pulse on zero or multi-hot sel.
REQ-010 The block SHALL have ports: err_seq output 1, one-cycle pulse on out-of-order position.
REQ-011 The block SHALL have ports: overrun output 1, one-cycle pulse when a complete frame is dropped.
REQ-012 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-013 sel/segm SHALL be registered once (stage S1); decode, error checks and buffer write SHALL occur on the next edge (stage S2).
REQ-014 Decode table (segm hex -> ASCII): 0x3BC0->'A', 0x3C52->'B', 0x2780->'E', 0x0700->'L', 0x1B24->'N', 0x3F00->'O', 0x33C0->'P', 0x36C0->'2', 0x3C40->'3', 0x3F09->'0', 0x0000->' '; any other pattern SHALL decode to '?' (0x3F).
REQ-015 A sel value that is not one-hot SHALL pulse err_sel, write nothing, and return the capture FSM to SYNC.
REQ-016 The capture FSM SHALL have states SYNC and CAPTURE, with expected position exp[3:0].
REQ-017 In SYNC, position 0 SHALL write buffer[0], set exp=1, and enter CAPTURE; other positions SHALL be ignored without an error.
REQ-018 In CAPTURE, position == exp SHALL write buffer[exp] and increment exp.
REQ-019 In CAPTURE, position != exp SHALL pulse err_seq; if that position is 0, the block SHALL restart the frame (write buffer[0], exp=1); otherwise it SHALL go to SYNC.
REQ-020 Writing position 11 SHALL complete the frame and return the FSM to SYNC, ready to accept the next position 0 immediately (back-to-back frames).
REQ-021 Buffering SHALL be double-banked: one write bank and one read bank of 12x8 each.
REQ-022 On frame completion with the read bank empty, the banks SHALL swap on the same edge, and out_valid SHALL rise on the next cycle.
REQ-023 On frame completion with the read bank still draining, the block SHALL pulse overrun, discard the completed frame, and leave the read bank untouched.
REQ-024 The read side SHALL present chars 0..11 in order; a transfer SHALL occur on an edge with out_valid && out_ready.
REQ-025 out_char, out_valid and out_last SHALL stay stable while out_valid && !out_ready.
REQ-026 out_last SHALL be 1 only with char 11; after that transfer the read bank SHALL be empty and out_valid SHALL be 0 unless a swap occurs on the same edge.
REQ-027 A frame completing on the same edge as the final (char 11) transfer SHALL swap without overrun.
REQ-028 err_sel, err_seq and overrun SHALL be mutually exclusive per cycle, with err_sel taking priority.

Reset
REQ-029 While rst_n=0: out_valid, out_last, err_sel, err_seq and overrun SHALL be 0; out_char SHALL be 0x00; FSM SHALL be SYNC with exp=0; both banks SHALL be marked empty; S1 SHALL be cleared (sel=0, which is not flagged).
REQ-030 A reset assertion mid-frame or mid-drain SHALL discard all partial and buffered data.
REQ-031 The first S2 evaluation after reset deassertion SHALL NOT raise err_sel.

Configuration
REQ-032 With macro SEGM14_ERRCNT_EN defined, the block SHALL add output err_count[7:0], which increments on each err_sel, err_seq or overrun pulse, saturates at 255, and resets to 0.
REQ-033 Without SEGM14_ERRCNT_EN, the err_count port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then drive scan PABELLON2023 (positions 0..11, one per clock), with out_ready=1 -> 12 transfers 'P','A','B','E','L','L','O','N','2','0','2','3'; out_last only on '3'; no error pulses.
REQ-035 Same frame with out_ready=0 for 30 cycles, then 1 -> 'P' held stable; next complete frame pulses overrun once; first frame still drains intact.
REQ-036 sel=12'b000000000011 mid-frame -> err_sel one pulse; following positions ignored until position 0; next full frame delivered.
REQ-037 Scan 0,1,2,5 -> err_seq at 5; scan 0,1,0..11 -> err_seq at second 0, then full frame delivered.
REQ-038 segm=0x1234 at position 4 -> out_char 0x3F at index 4; no error.
REQ-039 Reset pulse during drain -> out_valid=0 immediately; err_count=0 when SEGM14_ERRCNT_EN is defined; after 300 bad sel cycles, err_count=255.
